reg_scan_display: RTL and testbench

Debug readout stage directly downstream of the single-cycle CPU top. It drives the CPU's register-select input, captures the returned register value and shows it as hex on an 8-digit multiplexed seven-segment display. Register selection steps manually by button pulse or automatically on a hold timer. The block sits beside sccomp on the board top and replaces the testbench's fixed reg_sel drive.

---
 rtl/reg_scan_display.sv | 120 ++++++++++++
 tb/tb_reg_scan_display.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/reg_scan_display.sv
// Register readout: steps the CPU reg_sel, snapshots reg_data and scans it as hex onto an 8-digit 7-seg display.
// Optional INDEX_OVERLAY_EN: digits 7..6 show the register index, digits 5..0 show data[23:0].
module reg_scan_display #(
  parameter int unsigned DIGIT_DIV   = 50000,
  parameter int unsigned HOLD_CYCLES = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        auto_en,
  input  logic        step,
  input  logic        freeze,
  output logic [4:0]  reg_sel,
  input  logic [31:0] reg_data,
  output logic [7:0]  disp_an,
  output logic [7:0]  disp_seg
);

  localparam int unsigned DW = (DIGIT_DIV > 1) ? $clog2(DIGIT_DIV) : 1;
  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(DIGIT_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    SCAN0 = 3'd0, SCAN1 = 3'd1, SCAN2 = 3'd2, SCAN3 = 3'd3,
    SCAN4 = 3'd4, SCAN5 = 3'd5, SCAN6 = 3'd6, SCAN7 = 3'd7
  } scan_t;

  scan_t         scan_q, scan_d;
  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [31:0]   snapshot;
  logic          step_q;
  logic          step_rise, auto_term, adv_any, div_term;
  logic [31:0]   word;
  logic [3:0]    nibble;
  logic          dp;
  logic [7:0]    an_d, seg_d;

`ifdef INDEX_OVERLAY_EN
  logic [4:0]    sel_d;
`endif

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    step_rise = step & ~step_q;
    auto_term = auto_en && (hold_q == HOLD_LAST);
    adv_any   = step_rise | auto_term;

    // A manual step restarts the hold period so the new register gets a full display interval
    if (!auto_en || step_rise || auto_term) hold_d = '0;
    else                                    hold_d = hold_q + 1'b1;

    div_term = (div_q == DIV_LAST);
    div_d    = div_term ? '0 : div_q + 1'b1;
    scan_d   = div_term ? scan_t'(scan_q + 3'd1) : scan_q;

`ifdef INDEX_OVERLAY_EN
    word = {3'b000, sel_d, snapshot[23:0]};
    dp   = ~((scan_q == SCAN0 && auto_en) || (scan_q == SCAN6));
`else
    word = snapshot;
    dp   = ~(scan_q == SCAN0 && auto_en);
`endif

    nibble = word[{scan_q, 2'b00} +: 4];
    an_d   = ~(8'd1 << scan_q);
    seg_d  = {dp, hex7(nibble)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_q   <= SCAN0;
      div_q    <= '0;
      hold_q   <= '0;
      step_q   <= 1'b0;
      reg_sel  <= '0;
      snapshot <= '0;
      disp_an  <= '1;
      disp_seg <= '1;
    end else begin
      scan_q   <= scan_d;
      div_q    <= div_d;
      hold_q   <= hold_d;
      step_q   <= step;
      if (adv_any) reg_sel <= reg_sel + 5'd1;
      if (!freeze) snapshot <= reg_data;
      disp_an  <= an_d;
      disp_seg <= seg_d;
    end
  end

`ifdef INDEX_OVERLAY_EN
  // Index copy follows the snapshot's enable so both halves always describe the same register
  always_ff @(posedge clk) begin
    if (rst)          sel_d <= '0;
    else if (!freeze) sel_d <= reg_sel;
  end
`endif

endmodule

// File: tb/tb_reg_scan_display.sv
// Directed self-checking bench for reg_scan_display (DIGIT_DIV=4, HOLD_CYCLES=10).
module tb_reg_scan_display;

  logic        clk = 1'b0;
  logic        rst;
  logic        auto_en;
  logic        step;
  logic        freeze;
  logic [4:0]  reg_sel;
  logic [31:0] reg_data;
  logic [7:0]  disp_an;
  logic [7:0]  disp_seg;

  int errors = 0;
  int checks = 0;

  logic [7:0] scan_exp [8];

  reg_scan_display #(.DIGIT_DIV(4), .HOLD_CYCLES(10)) dut (
    .clk(clk), .rst(rst), .auto_en(auto_en), .step(step), .freeze(freeze),
    .reg_sel(reg_sel), .reg_data(reg_data), .disp_an(disp_an), .disp_seg(disp_seg)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_digit(input int unsigned d, input logic [7:0] exp, input string tag);
    int unsigned n = 0;
    logic [7:0] an_exp = ~(8'd1 << d);
    while (disp_an !== an_exp && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk({tag, "_timeout"}, {24'd0, disp_an}, {24'd0, an_exp});
    else         chk(tag, {24'd0, disp_seg}, {24'd0, exp});
  endtask

  task automatic pulse();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    scan_exp = '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80};
`ifdef INDEX_OVERLAY_EN
    scan_exp[6] = 8'h40;
    scan_exp[7] = 8'hC0;
`endif
    rst = 1'b1; auto_en = 1'b0; step = 1'b0; freeze = 1'b0;
    reg_data = 32'h89ABCDEF;

    // Reset
    repeat (2) @(negedge clk);
    chk("rst_reg_sel", {27'd0, reg_sel}, 32'd0);
    chk("rst_an", {24'd0, disp_an}, 32'hFF);
    chk("rst_seg", {24'd0, disp_seg}, 32'hFF);
    rst = 1'b0;
    @(negedge clk);
    chk("release_an", {24'd0, disp_an}, 32'hFE);
    chk("release_seg", {24'd0, disp_seg}, 32'hC0);

    // Scan walk, one digit every 4 cycles
    @(negedge clk);
    for (int unsigned k = 0; k < 8; k++) begin
      chk($sformatf("scan_an%0d", k), {24'd0, disp_an}, {24'd0, ~(8'd1 << k)});
      chk($sformatf("scan_seg%0d", k), {24'd0, disp_seg}, {24'd0, scan_exp[k]});
      repeat (4) @(negedge clk);
    end
    chk("scan_wrap_an", {24'd0, disp_an}, 32'hFE);
    chk("scan_wrap_seg", {24'd0, disp_seg}, 32'h8E);

    // Manual step: held high advances once
    step = 1'b1;
    @(negedge clk);
    chk("step_first", {27'd0, reg_sel}, 32'd1);
    repeat (4) @(negedge clk);
    chk("step_held", {27'd0, reg_sel}, 32'd1);
    step = 1'b0;
    @(negedge clk);
    for (int unsigned i = 0; i < 30; i++) pulse();
    chk("step_to_31", {27'd0, reg_sel}, 32'd31);
    pulse();
    chk("step_wrap", {27'd0, reg_sel}, 32'd0);

    // Freeze then release
    freeze = 1'b1;
    reg_data = 32'h00000001;
    repeat (3) @(negedge clk);
    check_digit(0, 8'h8E, "frozen_d0");
    freeze = 1'b0;
    repeat (2) @(negedge clk);
    check_digit(0, 8'hF9, "unfrozen_d0");
    check_digit(1, 8'hC0, "unfrozen_d1");

    // Auto stepping every 10 cycles
    reg_data = 32'h89ABCDEF;
    auto_en = 1'b1;
    repeat (9) @(negedge clk);
    chk("auto_pre1", {27'd0, reg_sel}, 32'd0);
    @(negedge clk);
    chk("auto_1", {27'd0, reg_sel}, 32'd1);
    repeat (9) @(negedge clk);
    chk("auto_pre2", {27'd0, reg_sel}, 32'd1);
    @(negedge clk);
    chk("auto_2", {27'd0, reg_sel}, 32'd2);
    repeat (9) @(negedge clk);
    chk("auto_pre3", {27'd0, reg_sel}, 32'd2);
    step = 1'b1;
    @(negedge clk);
    chk("coincident_single", {27'd0, reg_sel}, 32'd3);
    repeat (9) @(negedge clk);
    chk("coincident_restart", {27'd0, reg_sel}, 32'd3);
    @(negedge clk);
    chk("auto_4", {27'd0, reg_sel}, 32'd4);
    step = 1'b0;
    repeat (5) @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    chk("mid_hold_step", {27'd0, reg_sel}, 32'd5);
    step = 1'b0;
    repeat (9) @(negedge clk);
    chk("step_clears_hold", {27'd0, reg_sel}, 32'd5);
    @(negedge clk);
    chk("auto_6", {27'd0, reg_sel}, 32'd6);

    check_digit(0, 8'h0E, "auto_dp_d0");
    check_digit(1, 8'h86, "auto_nodp_d1");
    auto_en = 1'b0;
    repeat (2) @(negedge clk);
    check_digit(0, 8'h8E, "manual_nodp_d0");

    // Reset mid-operation
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_reg_sel", {27'd0, reg_sel}, 32'd0);
    chk("midrst_an", {24'd0, disp_an}, 32'hFF);
    chk("midrst_seg", {24'd0, disp_seg}, 32'hFF);
    rst = 1'b0;
    @(negedge clk);

`ifdef INDEX_OVERLAY_EN
    reg_data = 32'h00ABCDEF;
    for (int unsigned i = 0; i < 19; i++) pulse();
    chk("ovl_reg_sel", {27'd0, reg_sel}, 32'h13);
    repeat (3) @(negedge clk);
    check_digit(7, 8'hF9, "ovl_d7");
    check_digit(6, 8'h30, "ovl_d6");
    check_digit(5, 8'h88, "ovl_d5");
    check_digit(0, 8'h8E, "ovl_d0");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
